// File: rtl/operand_issue_stage.sv
// operand_issue_stage
//   Operand-fetch / issue stage between decode and execute. Holds the
//   architectural register file and a per-register busy scoreboard, stalls
//   decoded instructions on RAW/WAW hazards and issues registered operands
//   plus an opaque payload downstream.
//
//   Build option: define ISSUE_BYPASS_EN to let a write-back release a
//   stalled consumer in the same cycle and forward iWbData to its operands.
//   Without it, a write-back becomes visible one cycle later.
//
// Ports
//   iClk, iRst                    clock, synchronous active-high reset
//   iInValid / oInReady           decoded-instruction handshake
//   iRs1Idx/iRs2Idx, iRs1Used/iRs2Used   source indices and use flags
//   iRdIdx, iRdWrite              destination index / write enable
//   iPayload                      opaque control bits
//   oOutValid / iOutReady         issue handshake to execute
//   oRs1Data/oRs2Data, oRdIdx, oRdWrite, oPayload   issued fields
//   iWbValid, iWbIdx, iWbData     write-back port
module operand_issue_stage #(
    parameter int XLEN      = 32,
    parameter int REG_NUM   = 32,
    parameter int PAYLOAD_W = 49,
    localparam int IDX_W    = $clog2(REG_NUM)
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iInValid,
    output logic                 oInReady,
    input  logic [IDX_W-1:0]     iRs1Idx,
    input  logic [IDX_W-1:0]     iRs2Idx,
    input  logic                 iRs1Used,
    input  logic                 iRs2Used,
    input  logic [IDX_W-1:0]     iRdIdx,
    input  logic                 iRdWrite,
    input  logic [PAYLOAD_W-1:0] iPayload,
    output logic                 oOutValid,
    input  logic                 iOutReady,
    output logic [XLEN-1:0]      oRs1Data,
    output logic [XLEN-1:0]      oRs2Data,
    output logic [IDX_W-1:0]     oRdIdx,
    output logic                 oRdWrite,
    output logic [PAYLOAD_W-1:0] oPayload,
    input  logic                 iWbValid,
    input  logic [IDX_W-1:0]     iWbIdx,
    input  logic [XLEN-1:0]      iWbData
);

    localparam logic [REG_NUM-1:0] ONE_HOT0 = {{(REG_NUM-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]      r_regs [REG_NUM];
    logic [REG_NUM-1:0]   r_busy;
    logic                 r_out_valid;
    logic [XLEN-1:0]      r_rs1_data;
    logic [XLEN-1:0]      r_rs2_data;
    logic [IDX_W-1:0]     r_rd_idx;
    logic                 r_rd_write;
    logic [PAYLOAD_W-1:0] r_payload;

    logic [REG_NUM-1:0]   w_wb_mask;
    logic [REG_NUM-1:0]   w_set_mask;
    logic [REG_NUM-1:0]   w_busy_eff;
    logic                 w_hazard;
    logic                 w_accept;
    logic [XLEN-1:0]      w_rs1_data;
    logic [XLEN-1:0]      w_rs2_data;

    // Bit 0 is masked so x0 can never become busy.
    assign w_wb_mask  = iWbValid ? (ONE_HOT0 << iWbIdx) : '0;
    assign w_set_mask = (w_accept && iRdWrite) ? ((ONE_HOT0 << iRdIdx) & ~ONE_HOT0) : '0;

`ifdef ISSUE_BYPASS_EN
    // The write-back in flight already counts as done for hazard checks.
    assign w_busy_eff = r_busy & ~w_wb_mask;
`else
    assign w_busy_eff = r_busy;
`endif

    assign w_hazard = (iRs1Used && w_busy_eff[iRs1Idx]) ||
                      (iRs2Used && w_busy_eff[iRs2Idx]) ||
                      (iRdWrite && w_busy_eff[iRdIdx]);

    assign oInReady = !iRst && !w_hazard && (!r_out_valid || iOutReady);
    assign w_accept = iInValid && oInReady;

    // Operand read: x0 -> 0, then bypass (if built), then register file.
    always_comb begin
        w_rs1_data = r_regs[iRs1Idx];
        w_rs2_data = r_regs[iRs2Idx];
`ifdef ISSUE_BYPASS_EN
        if (iWbValid && (iWbIdx == iRs1Idx)) w_rs1_data = iWbData;
        if (iWbValid && (iWbIdx == iRs2Idx)) w_rs2_data = iWbData;
`endif
        if (iRs1Idx == '0) w_rs1_data = '0;
        if (iRs2Idx == '0) w_rs2_data = '0;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_busy      <= '0;
            r_out_valid <= 1'b0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_rd_idx    <= '0;
            r_rd_write  <= 1'b0;
            r_payload   <= '0;
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
        end else begin
            // Set is applied after clear so a same-index collision stays busy.
            r_busy <= (r_busy & ~w_wb_mask) | w_set_mask;

            if (iWbValid && (iWbIdx != '0)) r_regs[iWbIdx] <= iWbData;

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_rs1_data  <= w_rs1_data;
                r_rs2_data  <= w_rs2_data;
                r_rd_idx    <= iRdIdx;
                r_rd_write  <= iRdWrite;
                r_payload   <= iPayload;
            end else if (r_out_valid && iOutReady) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign oOutValid = r_out_valid;
    assign oRs1Data  = r_rs1_data;
    assign oRs2Data  = r_rs2_data;
    assign oRdIdx    = r_rd_idx;
    assign oRdWrite  = r_rd_write;
    assign oPayload  = r_payload;

endmodule
